multicycle_ctrl: RTL

- Multi-cycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over a shared datapath: PC, IR, register file, immediate generator, ALU, MDR.
- Drives the immediate generator's format select, ALU operand muxes and register/PC write enables.
- Holds a valid/ready handshake with the instruction memory and the data memory.

---
 rtl/multicycle_pkg.sv | 31 +++
 rtl/ctrl_decode.sv | 27 ++
 rtl/multicycle_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared encodings for the multi-cycle RV32I control FSM
package multicycle_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_NONE
  } cls_t;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;
  localparam logic [1:0] PC_SRC_PC4  = 2'd0;
  localparam logic [1:0] PC_SRC_ALU  = 2'd1;
  localparam logic [1:0] PC_SRC_JALR = 2'd2;
  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode classifier giving instruction class, immediate format and legality
module ctrl_decode
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode_i,
  output cls_t       cls_o,
  output logic [2:0] imm_sel_o,
  output logic       legal_o
);
  always_comb begin
    cls_o = C_NONE;
    imm_sel_o = IMM_NONE;
    legal_o = 1'b1;
    case (opcode_i)
      OPC_OP:     cls_o = C_OP;
      OPC_OPIMM:  begin cls_o = C_OPIMM;  imm_sel_o = IMM_I; end
      OPC_LOAD:   begin cls_o = C_LOAD;   imm_sel_o = IMM_I; end
      OPC_STORE:  begin cls_o = C_STORE;  imm_sel_o = IMM_S; end
      OPC_BRANCH: begin cls_o = C_BRANCH; imm_sel_o = IMM_B; end
      OPC_JAL:    begin cls_o = C_JAL;    imm_sel_o = IMM_J; end
      OPC_JALR:   begin cls_o = C_JALR;   imm_sel_o = IMM_I; end
      OPC_LUI:    begin cls_o = C_LUI;    imm_sel_o = IMM_U; end
      OPC_AUIPC:  begin cls_o = C_AUIPC;  imm_sel_o = IMM_U; end
      default:    legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM; define MULTICYCLE_CTRL_PERF_EN for cycle/instret counters
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned RESET_STALL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       br_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic       mdr_we,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);
  localparam logic [3:0] STALL_LAST = 4'(RESET_STALL - 1);
  state_t state_q, state_d;
  cls_t cls_q, cls_d, dec_cls;
  logic [2:0] imm_q, imm_d, dec_imm;
  logic [3:0] stall_q, stall_d;
  logic dec_legal, is_br, is_jal, is_jalr, is_ld, is_st;
  logic unused_funct3;
  assign unused_funct3 = ^funct3;
  ctrl_decode u_dec (.opcode_i(opcode), .cls_o(dec_cls), .imm_sel_o(dec_imm), .legal_o(dec_legal));
  assign is_br = cls_q == C_BRANCH;
  assign is_jal = cls_q == C_JAL;
  assign is_jalr = cls_q == C_JALR;
  assign is_ld = cls_q == C_LOAD;
  assign is_st = cls_q == C_STORE;
  assign imm_sel = state_q == S_DECODE ? dec_imm : imm_q;
  assign illegal = state_q == S_TRAP;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q <= C_NONE;
      imm_q <= IMM_NONE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      imm_q <= imm_d;
      stall_q <= stall_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    imm_d = imm_q;
    stall_d = stall_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_src = PC_SRC_PC4;
    alu_a_sel = ALU_A_RS1;
    alu_b_sel = 1'b0;
    mdr_we = 1'b0;
    reg_we = 1'b0;
    wb_sel = WB_ALU;
    case (state_q)
      S_IDLE: begin
        stall_d = stall_q == STALL_LAST ? '0 : stall_q + 4'd1;
        state_d = stall_q == STALL_LAST ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we = imem_ready;
        pc_we = imem_ready;
        state_d = imem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        cls_d = dec_cls;
        imm_d = dec_imm;
        state_d = dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_a_sel = (is_br | is_jal | cls_q == C_AUIPC) ? ALU_A_PC :
                    cls_q == C_LUI ? ALU_A_ZERO : ALU_A_RS1;
        alu_b_sel = cls_q != C_OP;
        pc_we = (is_br & br_taken) | is_jal | is_jalr;
        pc_src = is_jalr ? PC_SRC_JALR : (is_br | is_jal) ? PC_SRC_ALU : PC_SRC_PC4;
        state_d = is_br ? S_FETCH : (is_ld | is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we = is_st;
        mdr_we = is_ld & dmem_ready;
        state_d = !dmem_ready ? S_MEM : is_st ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we = 1'b1;
        wb_sel = is_ld ? WB_MDR : (is_jal | is_jalr) ? WB_PC4 : WB_ALU;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_q, ins_q;
  logic active, retire;
  assign active = state_q != S_IDLE && state_q != S_TRAP;
  assign retire = state_q == S_WB || (state_q == S_EXEC && is_br) ||
                  (state_q == S_MEM && is_st && dmem_ready);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + {31'd0, active};
      ins_q <= ins_q + {31'd0, retire};
    end
  end
  assign cycle_cnt = cyc_q;
  assign instret_cnt = ins_q;
`endif
endmodule
